// File: rtl/nios_pio_gen2.sv
// Avalon-MM GPIO peripheral: output register with atomic set/clear, direction
// register, synchronised inputs, edge capture with mask and level IRQ.
module nios_pio_gen2 #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0000_0000,
  parameter int          EDGE_TYPE   = 0,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic [DATA_WIDTH-1:0] out_en,
  output logic                  irq
);

  localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];
  localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
  localparam logic [2:0]            ARM_MAX  = 3'(SYNC_STAGES + 1);

  logic [DATA_WIDTH-1:0] r_data_out;
  logic [DATA_WIDTH-1:0] r_dir;
  logic [DATA_WIDTH-1:0] r_irq_mask;
  logic [DATA_WIDTH-1:0] r_edge_cap;
  logic [DATA_WIDTH-1:0] r_prev;
  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [2:0]            r_arm_cnt;

  logic                  w_wr;
  logic                  w_armed;
  logic [DATA_WIDTH-1:0] w_wd;
  logic [DATA_WIDTH-1:0] w_sync_in;
  logic [DATA_WIDTH-1:0] w_edge;
  logic [DATA_WIDTH-1:0] w_edge_valid;
  logic [DATA_WIDTH-1:0] w_clr;
  logic [31:0]           w_rdata;
  logic                  w_unused;

  assign w_wr      = chipselect & ~write_n;
  assign w_wd      = writedata[DATA_WIDTH-1:0];
  assign w_unused  = &{1'b0, writedata};
  assign w_sync_in = r_sync[SYNC_STAGES-1];
  assign w_armed   = (r_arm_cnt == ARM_MAX);

  // Per-bit edge detect selected by the capture mode
  always_comb begin
    w_edge = ZERO_W;
    case (EDGE_TYPE)
      1:       w_edge = ~w_sync_in & r_prev;
      2:       w_edge = w_sync_in ^ r_prev;
      default: w_edge = w_sync_in & ~r_prev;
    endcase
  end

  // Edges are suppressed until the synchroniser has flushed its reset contents
  assign w_edge_valid = w_armed ? w_edge : ZERO_W;
  assign w_clr        = (w_wr && (address == 3'd3)) ? w_wd : ZERO_W;

  // Software-visible control registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data_out <= RST_DATA;
      r_dir      <= ZERO_W;
      r_irq_mask <= ZERO_W;
    end else if (w_wr) begin
      case (address)
        3'd0:    r_data_out <= w_wd;
        3'd1:    r_dir      <= w_wd;
        3'd2:    r_irq_mask <= w_wd;
        3'd4:    r_data_out <= r_data_out | w_wd;
        3'd5:    r_data_out <= r_data_out & ~w_wd;
        default: ;
      endcase
    end
  end

  // Input synchroniser, previous-sample register and edge capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync     <= {(SYNC_STAGES * DATA_WIDTH){1'b0}};
      r_prev     <= ZERO_W;
      r_edge_cap <= ZERO_W;
    end else begin
      r_sync     <= {r_sync[SYNC_STAGES-2:0], in_port};
      r_prev     <= w_sync_in;
      r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge_valid;
    end
  end

  // Saturating arm counter restarted by every reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_arm_cnt <= 3'd0;
    end else if (r_arm_cnt != ARM_MAX) begin
      r_arm_cnt <= r_arm_cnt + 3'd1;
    end
  end

  // Zero-wait-state read mux, independent of chipselect
  always_comb begin
    w_rdata = 32'd0;
    case (address)
      3'd0:    w_rdata[DATA_WIDTH-1:0] = w_sync_in;
      3'd1:    w_rdata[DATA_WIDTH-1:0] = r_dir;
      3'd2:    w_rdata[DATA_WIDTH-1:0] = r_irq_mask;
      3'd3:    w_rdata[DATA_WIDTH-1:0] = r_edge_cap;
      default: w_rdata = 32'd0;
    endcase
  end

  assign readdata = w_rdata;
  assign out_port = r_data_out;
  assign out_en   = r_dir;
  assign irq      = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_nios_pio_gen2.sv
// Scoreboard bench: three instances (rising, falling, any edge) driven in
// parallel and compared every cycle against a behavioural model.
module tb_nios_pio_gen2;

  localparam int S = 2;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] rdv  [3];
  logic [7:0]  outp [3];
  logic [7:0]  oen  [3];
  logic        irqv [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nios_pio_gen2 #(
      .DATA_WIDTH (8),
      .RESET_VALUE(32'h0000_00A5),
      .EDGE_TYPE  (g),
      .SYNC_STAGES(S)
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (rdv[g]),
      .in_port   (in_port),
      .out_port  (outp[g]),
      .out_en    (oen[g]),
      .irq       (irqv[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]        op;
    logic [7:0]        oe;
    logic [2:0]        irq;
    logic [2:0][31:0]  rd;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: registers plus a history of sampled in_port values
  logic [7:0] m_data, m_dir, m_mask;
  logic [7:0] m_ec [3];
  logic [7:0] m_samp[$];   // index 0 = most recent sample
  int         m_edges;
  logic [7:0] pin;

  function automatic void m_reset();
    m_data = 8'hA5;
    m_dir  = 8'h00;
    m_mask = 8'h00;
    for (int m = 0; m < 3; m++) m_ec[m] = 8'h00;
    m_samp.delete();
    for (int k = 0; k <= S; k++) m_samp.push_back(8'h00);
    m_edges = 0;
  endfunction

  function automatic exp_t m_expect(input logic [2:0] a);
    exp_t r;
    r.op = m_data;
    r.oe = m_dir;
    for (int m = 0; m < 3; m++) begin
      r.irq[m] = |(m_ec[m] & m_mask);
      case (a)
        3'd0:    r.rd[m] = {24'd0, m_samp[S-1]};
        3'd1:    r.rd[m] = {24'd0, m_dir};
        3'd2:    r.rd[m] = {24'd0, m_mask};
        3'd3:    r.rd[m] = {24'd0, m_ec[m]};
        default: r.rd[m] = 32'd0;
      endcase
    end
    return r;
  endfunction

  function automatic void m_step(input logic cs, input logic wn, input logic [2:0] a,
                                 input logic [7:0] wd, input logic [7:0] inp);
    logic       wr;
    logic [7:0] cur, prv, clr;
    logic [7:0] edg [3];
    wr  = cs & ~wn;
    cur = m_samp[S-1];
    prv = m_samp[S];
    edg[0] = cur & ~prv;
    edg[1] = ~cur & prv;
    edg[2] = cur ^ prv;
    clr = (wr && a == 3'd3) ? wd : 8'h00;
    for (int m = 0; m < 3; m++)
      m_ec[m] = (m_ec[m] & ~clr) | ((m_edges >= S + 1) ? edg[m] : 8'h00);
    if (wr) begin
      case (a)
        3'd0: m_data = wd;
        3'd1: m_dir  = wd;
        3'd2: m_mask = wd;
        3'd4: m_data = m_data | wd;
        3'd5: m_data = m_data & ~wd;
        default: ;
      endcase
    end
    m_samp.push_front(inp);
    void'(m_samp.pop_back());
    if (m_edges < 1000) m_edges++;
  endfunction

  task automatic cyc(input logic rst, input logic cs, input logic wn,
                     input logic [2:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    reset_n    = rst;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = pin;
    if (!rst) m_reset();
    expq.push_back(m_expect(a));
    if (rst) m_step(cs, wn, a, wd[7:0], pin);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cyc(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd(input logic [2:0] a);
    cyc(1'b1, 1'b1, 1'b1, a, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, 1'b1, 3'(k), 32'hFFFF_FFFF);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expected record per cycle, compared on the falling edge
  exp_t e;
  always @(negedge clk) begin
    if (expq.size() > 0) begin
      e = expq.pop_front();
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("out_port[%0d]", m), {24'd0, outp[m]}, {24'd0, e.op});
        chk($sformatf("out_en[%0d]", m),   {24'd0, oen[m]},  {24'd0, e.oe});
        chk($sformatf("irq[%0d]", m),      {31'd0, irqv[m]}, {31'd0, e.irq[m]});
        chk($sformatf("readdata[%0d]", m), rdv[m],           e.rd[m]);
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 3'd0;
    writedata  = 32'd0;
    pin        = 8'hFF;
    in_port    = pin;
    m_reset();

    // Reset with pins high, then power-up suppression with all bits unmasked
    for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 1'b1, 3'(k), 32'd0);
    for (int a = 0; a < 8; a++) rd(3'(a));
    wr(3'd2, 32'h0000_00FF);
    idle(6);
    rd(3'd3);

    // Set/clear sequence, upper writedata bits ignored
    wr(3'd0, 32'hDEAD_BE0F);
    wr(3'd4, 32'h0000_00F0);
    wr(3'd5, 32'hFFFF_FF3C);
    rd(3'd4);
    rd(3'd5);
    wr(3'd1, 32'h0000_0055);
    wr(3'd6, 32'h0000_00FF);
    wr(3'd7, 32'h0000_00FF);

    // Synchroniser latency: 00 -> 81
    pin = 8'h00;
    idle(4);
    wr(3'd3, 32'h0000_00FF);
    pin = 8'h81;
    for (int k = 0; k < 5; k++) rd(3'(k % 2 == 0 ? 0 : 3));

    // IRQ / clear race on bit0 at several relative offsets
    wr(3'd2, 32'h0000_0001);
    for (int d = 0; d < 6; d++) begin
      pin = 8'h00;
      idle(4);
      pin = 8'h01;
      idle(d);
      wr(3'd3, 32'h0000_0001);
      rd(3'd3);
    end
    idle(4);
    wr(3'd3, 32'h0000_0001);
    idle(3);

    // Pulse on bit3 for the edge-mode instances
    pin = 8'h00;
    idle(4);
    wr(3'd3, 32'h0000_00FF);
    wr(3'd2, 32'h0000_0008);
    pin = 8'h08;
    idle(3);
    pin = 8'h00;
    idle(4);
    rd(3'd3);

    // Randomised traffic with a mid-run reset pulse
    for (int k = 0; k < 500; k++) begin
      if (k == 250) begin
        cyc(1'b0, 1'b1, 1'b0, 3'd0, 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 3'd3, 32'd0);
      end
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      cyc(1'b1, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), $urandom);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d records left, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
